ones_comp_serial_alu: RTL and testbench

- Sequential, bit-serial ones'-complement add/subtract stage.
- Sits directly upstream of the 4-bit ones'-complement display/result path.
- Accepts an operand pair over a valid/ready handshake and reuses the existing single fulladder cell, one bit per clock.
- Applies the end-around carry in a second serial pass, then presents a registered result with a valid/ready handshake.

---
 rtl/ones_comp_pkg.sv | 18 +
 rtl/fulladder.sv | 13 +
 rtl/ones_comp_serial_alu.sv | 177 +++++++++++++++++
 tb/tb_ones_comp_serial_alu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_comp_pkg.sv
// Shared encodings for the bit-serial ones'-complement add/subtract stage.
package ones_comp_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PASS1 = 2'd1;
    localparam logic [1:0] S_PASS2 = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_PASS1 = S_PASS1,
        ST_PASS2 = S_PASS2,
        ST_DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell shared by both serial passes.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Y,
    output logic Carry
);

    assign Y     = A ^ B ^ Cin;
    assign Carry = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/ones_comp_serial_alu.sv
// Bit-serial ones'-complement adder/subtractor: one full-adder evaluation per
// clock, first over the operands, then (only if the MSB carried out) a second
// pass that folds the end-around carry back into the partial sum.
module ones_comp_serial_alu
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             eac,
    output logic             neg_zero,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             eac_pend_q, eac_pend_d;
    logic             eac_q, eac_d;
    logic             nz_q, nz_d;

    logic             fa_a_s, fa_b_s, fa_y_s, fa_c_s;
    logic [WIDTH-1:0] sum_wr_s;

    // Operand mux into the shared adder: operands in PASS1, partial sum plus carry in PASS2
    always_comb begin
        fa_a_s = 1'b0;
        fa_b_s = 1'b0;
        if (state_q == ST_PASS2) begin
            fa_a_s = sum_q[idx_q];
            fa_b_s = 1'b0;
        end else begin
            fa_a_s = opa_q[idx_q];
            fa_b_s = opb_q[idx_q];
        end
    end

    fulladder u_fa (
        .A     (fa_a_s),
        .B     (fa_b_s),
        .Cin   (carry_q),
        .Y     (fa_y_s),
        .Carry (fa_c_s)
    );

    // Partial sum with the current bit replaced by the adder output
    always_comb begin
        sum_wr_s        = sum_q;
        sum_wr_s[idx_q] = fa_y_s;
    end

    // Next-state and datapath update for the serial FSM
    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        sum_d      = sum_q;
        result_d   = result_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        eac_pend_d = eac_pend_q;
        eac_d      = eac_q;
        nz_d       = nz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opa_d   = A;
                    opb_d   = sub ? ~B : B;
                    sum_d   = {WIDTH{1'b0}};
                    idx_d   = {IDX_W{1'b0}};
                    carry_d = 1'b0;
                    state_d = ST_PASS1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS1: begin
                sum_d   = sum_wr_s;
                carry_d = fa_c_s;
                if (idx_q == IDX_LAST) begin
                    idx_d = {IDX_W{1'b0}};
                    if (fa_c_s) begin
                        // MSB carried out: add it back in at bit 0
                        eac_pend_d = 1'b1;
                        carry_d    = 1'b1;
                        state_d    = ST_PASS2;
                    end else begin
                        eac_pend_d = 1'b0;
                        carry_d    = 1'b0;
                        result_d   = sum_wr_s;
                        eac_d      = 1'b0;
                        nz_d       = &sum_wr_s;
                        state_d    = ST_DONE;
                    end
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_PASS2: begin
                sum_d   = sum_wr_s;
                carry_d = fa_c_s;
                if (idx_q == IDX_LAST) begin
                    // Final carry-out cannot be set in ones' complement; drop it
                    idx_d    = {IDX_W{1'b0}};
                    carry_d  = 1'b0;
                    result_d = sum_wr_s;
                    eac_d    = eac_pend_q;
                    nz_d     = &sum_wr_s;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            opa_q      <= {WIDTH{1'b0}};
            opb_q      <= {WIDTH{1'b0}};
            sum_q      <= {WIDTH{1'b0}};
            result_q   <= {WIDTH{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            carry_q    <= 1'b0;
            eac_pend_q <= 1'b0;
            eac_q      <= 1'b0;
            nz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            sum_q      <= sum_d;
            result_q   <= result_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            eac_pend_q <= eac_pend_d;
            eac_q      <= eac_d;
            nz_q       <= nz_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_PASS1) || (state_q == ST_PASS2);
    assign result    = result_q;
    assign eac       = eac_q;
    assign neg_zero  = nz_q;

endmodule

// File: tb/tb_ones_comp_serial_alu.sv
// Self-checking bench for the bit-serial ones'-complement add/subtract stage.
module tb_ones_comp_serial_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         eac;
    logic         neg_zero;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [3:0] r;
        logic       e;
        logic       nz;
    } vec_t;

    typedef struct {
        logic [3:0] r;
        logic       e;
        logic       nz;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    ones_comp_serial_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .eac       (eac),
        .neg_zero  (neg_zero),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: whole-word add, then fold the carry back in
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic s);
        logic [4:0] f;
        logic [3:0] bb;
        exp_t       x;
        bb = s ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb};
        if (f[4]) begin
            x.r = f[3:0] + 4'd1;
            x.e = 1'b1;
        end else begin
            x.r = f[3:0];
            x.e = 1'b0;
        end
        x.nz  = (x.r == 4'hF);
        x.lat = x.e ? 2 * W : W;
        return x;
    endfunction

    // Drive one operand pair at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic s, input exp_t x);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        A        = a;
        B        = b;
        sub      = s;
        in_valid = 1'b1;
        sbq.push_back(x);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    // Count edges until out_valid, then compare against the scoreboard head
    task automatic collect(input string tag);
        int   n;
        exp_t x;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 40);
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no out_valid after %0d cycles", tag, n);
        end else if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_unexpected: out_valid with empty scoreboard", tag);
        end else begin
            x = sbq.pop_front();
            check({tag, "_latency"}, n, x.lat);
            check({tag, "_result"}, {28'd0, result}, {28'd0, x.r});
            check({tag, "_eac"}, {31'd0, eac}, {31'd0, x.e});
            check({tag, "_neg_zero"}, {31'd0, neg_zero}, {31'd0, x.nz});
        end
    endtask

    // One-cycle out_ready pulse and verify the return to IDLE
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        exp_t x;
        logic [3:0] ra, rb;
        logic rs;

        vecs[0] = '{a: 4'b0101, b: 4'b0011, s: 1'b1, r: 4'b0010, e: 1'b1, nz: 1'b0};
        vecs[1] = '{a: 4'b0011, b: 4'b0101, s: 1'b1, r: 4'b1101, e: 1'b0, nz: 1'b0};
        vecs[2] = '{a: 4'b0110, b: 4'b0110, s: 1'b1, r: 4'b1111, e: 1'b0, nz: 1'b1};
        vecs[3] = '{a: 4'b0111, b: 4'b1110, s: 1'b0, r: 4'b0110, e: 1'b1, nz: 1'b0};
        vecs[4] = '{a: 4'b0000, b: 4'b0000, s: 1'b0, r: 4'b0000, e: 1'b0, nz: 1'b0};
        vecs[5] = '{a: 4'b1000, b: 4'b1000, s: 1'b0, r: 4'b0001, e: 1'b1, nz: 1'b0};
        vecs[6] = '{a: 4'b0101, b: 4'b0101, s: 1'b0, r: 4'b1010, e: 1'b0, nz: 1'b0};
        vecs[7] = '{a: 4'b1111, b: 4'b1111, s: 1'b0, r: 4'b1111, e: 1'b1, nz: 1'b1};
        vecs[8] = '{a: 4'b0000, b: 4'b0000, s: 1'b1, r: 4'b1111, e: 1'b0, nz: 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 4'd0;
        B         = 4'd0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_result", {28'd0, result}, 32'd0);
        check("reset_eac", {31'd0, eac}, 32'd0);
        check("reset_neg_zero", {31'd0, neg_zero}, 32'd0);
        reset = 1'b0;

        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_ready_noeffect", {30'd0, in_ready, out_valid}, 32'd2);

        // Table-driven operations
        for (int i = 0; i < 9; i++) begin
            x.r   = vecs[i].r;
            x.e   = vecs[i].e;
            x.nz  = vecs[i].nz;
            x.lat = vecs[i].e ? 2 * W : W;
            issue(vecs[i].a, vecs[i].b, vecs[i].s, x);
            collect($sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        // Random operations against the arithmetic reference
        for (int i = 0; i < 8; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, model(ra, rb, rs));
            collect($sformatf("rand%0d", i));
            drain($sformatf("rand%0d", i));
        end

        // Backpressure: hold the result while new operands are offered
        issue(4'b0101, 4'b0011, 1'b1, model(4'b0101, 4'b0011, 1'b1));
        collect("stall");
        for (int i = 0; i < 5; i++) begin
            A        = 4'b0001;
            B        = 4'b0001;
            sub      = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_result", {28'd0, result}, 32'd2);
            check("stall_eac", {31'd0, eac}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        drain("stall");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_no_queued_op", {30'd0, out_valid, busy}, 32'd0);

        // Reset during PASS2 aborts the operation
        issue(4'b0111, 4'b0000, 1'b0, model(4'b0111, 4'b0000, 1'b0));
        collect("pre_abort");
        drain("pre_abort");
        issue(4'b0101, 4'b0011, 1'b1, model(4'b0101, 4'b0011, 1'b1));
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result", {28'd0, result}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort_no_pulse", {31'd0, out_valid}, 32'd0);
        issue(4'b0011, 4'b0001, 1'b1, model(4'b0011, 4'b0001, 1'b1));
        collect("post_abort");
        check("post_abort_result_const", {28'd0, result}, 32'd2);
        drain("post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
